// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared types, tables and helpers for the byte-serial AES-128 core
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2,
        ST_FIN   = 2'd3
    } aes_state_t;

    localparam logic [7:0] c_LFSR_DATA_SEED = 8'h01;
    localparam logic [7:0] c_LFSR_KEY_SEED  = 8'hA5;
    localparam logic [7:0] c_MISR_SEED      = 8'h00;
    // x^8+x^6+x^5+x^4+1 as Fibonacci feedback taps on bits 7,5,4,3
    localparam logic [7:0] c_POLY_TAPS      = 8'hB8;

    localparam logic [0:9][7:0] c_RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[b];
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], ^(x & c_POLY_TAPS)};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : combinational 8-bit AES S-box lookup
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox(din);

endmodule

`default_nettype wire

// File: rtl/aes128_top_bist.sv
// ============================================================================
// aes128_top_bist : byte-serial AES-128 encryptor with optional LFSR/MISR
// self-test, compiled in when AES_BIST_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes128_top_bist
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic [7:0] d_in,
    input  logic       is_bist,
    input  logic       en_lsfr_misr,
    output logic [7:0] d_out,
    output logic       d_vld,
    output logic       DONE
);

    aes_state_t        r_state, w_state_nxt;
    logic [4:0]        r_cnt, w_cnt_nxt;
    logic [3:0]        r_rnd, w_rnd_nxt;
    logic [0:15][7:0]  r_st, r_key, w_sr, w_mc, w_key_nxt;
    logic [0:3][7:0]   r_tw;
    logic [31:0]       w_tmp, w_k0, w_k1, w_k2, w_k3;
    logic [7:0]        w_sb_a_in, w_sb_a_out, w_sb_b_in, w_sb_b_out;
    logic [7:0]        w_key_src, w_data_src, w_sig;
    logic              w_sig_sel, w_last_round;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 5'd1;
        w_rnd_nxt   = r_rnd;
        d_vld       = 1'b0;
        DONE        = 1'b0;
        d_out       = 8'h00;
        case (r_state)
            ST_LOAD: begin
                if (r_cnt == 5'd15) begin
                    w_state_nxt = ST_ROUND;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ROUND: begin
                if (r_cnt == 5'd16) begin
                    w_cnt_nxt = '0;
                    if (w_last_round) begin
                        w_state_nxt = ST_OUT;
                        w_rnd_nxt   = '0;
                    end else begin
                        w_rnd_nxt = r_rnd + 4'd1;
                    end
                end
            end
            ST_OUT: begin
                d_vld = 1'b1;
                d_out = r_st[r_cnt[3:0]];
                if (r_cnt == 5'd15) begin
                    w_state_nxt = ST_FIN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FIN: begin
                DONE      = 1'b1;
                w_cnt_nxt = r_cnt;
                d_out     = w_sig_sel ? w_sig : r_st[15];
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    assign w_last_round = (r_rnd == 4'd9);

    // Path A substitutes the state byte in place; path B builds
    // SubWord(RotWord(w3)), i.e. key bytes 13,14,15,12 in that order.
    assign w_sb_a_in = r_st[r_cnt[3:0]];
    assign w_sb_b_in = r_key[{2'b11, r_cnt[1:0] + 2'd1}];

    aes_sbox u_sbox_a (.din(w_sb_a_in), .dout(w_sb_a_out));
    aes_sbox u_sbox_b (.din(w_sb_b_in), .dout(w_sb_b_out));

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[4*c + r] = r_st[4*((c + r) % 4) + r];
        end
        assign w_mc[4*c +: 4] = w_last_round ? w_sr[4*c +: 4] : mix_column(w_sr[4*c +: 4]);
    end

    assign w_tmp     = r_tw ^ {c_RCON[r_rnd], 24'h000000};
    assign w_k0      = r_key[0:3]   ^ w_tmp;
    assign w_k1      = r_key[4:7]   ^ w_k0;
    assign w_k2      = r_key[8:11]  ^ w_k1;
    assign w_k3      = r_key[12:15] ^ w_k2;
    assign w_key_nxt = {w_k0, w_k1, w_k2, w_k3};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st  <= '0;
            r_key <= '0;
            r_tw  <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_key[r_cnt[3:0]] <= w_key_src;
                    r_st[r_cnt[3:0]]  <= w_data_src ^ w_key_src;
                end
                ST_ROUND: begin
                    if (r_cnt == 5'd16) begin
                        r_st  <= w_mc ^ w_key_nxt;
                        r_key <= w_key_nxt;
                    end else begin
                        r_st[r_cnt[3:0]] <= w_sb_a_out;
                        if (r_cnt < 5'd4) begin
                            r_tw[r_cnt[1:0]] <= w_sb_b_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_BIST_EN
    logic [7:0] r_lfsr_d, r_lfsr_k, r_misr;
    logic       r_bist, w_bist;

    // Mode is live on the first load edge, then frozen for the operation.
    assign w_bist     = (r_state == ST_LOAD && r_cnt == 5'd0) ? is_bist : r_bist;
    assign w_key_src  = w_bist ? r_lfsr_k : key_in;
    assign w_data_src = w_bist ? r_lfsr_d : d_in;
    assign w_sig      = r_misr;
    assign w_sig_sel  = r_bist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bist   <= 1'b0;
            r_lfsr_d <= c_LFSR_DATA_SEED;
            r_lfsr_k <= c_LFSR_KEY_SEED;
            r_misr   <= c_MISR_SEED;
        end else begin
            if (r_state == ST_LOAD && r_cnt == 5'd0) begin
                r_bist <= is_bist;
            end
            if (en_lsfr_misr) begin
                if (r_state == ST_LOAD) begin
                    r_lfsr_d <= lfsr_step(r_lfsr_d);
                    r_lfsr_k <= lfsr_step(r_lfsr_k);
                end
                if (r_state == ST_OUT) begin
                    r_misr <= lfsr_step(r_misr) ^ d_out;
                end
            end
        end
    end
`else
    logic w_unused_bist;

    assign w_key_src     = key_in;
    assign w_data_src    = d_in;
    assign w_sig         = 8'h00;
    assign w_sig_sel     = 1'b0;
    assign w_unused_bist = is_bist ^ en_lsfr_misr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes128_top_bist.sv
// ============================================================================
// tb_aes128_top_bist : directed, scoreboard-based bench for aes128_top_bist
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes128_top_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic [7:0] d_in = 8'h00;
    logic       is_bist = 1'b0;
    logic       en_lsfr_misr = 1'b0;
    logic [7:0] d_out;
    logic       d_vld;
    logic       DONE;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_n = 0;
    logic [7:0] exp_q[$];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes128_top_bist dut (
        .clk(clk), .rst(rst), .key_in(key_in), .d_in(d_in),
        .is_bist(is_bist), .en_lsfr_misr(en_lsfr_misr),
        .d_out(d_out), .d_vld(d_vld), .DONE(DONE)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %02h expected %02h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0b expected %0b", tag, edge_n, obs, exp);
        end
    endtask

    // Reference model: S-box from GF(2^8) inverse + affine map, gmul MixColumns.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbx(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] lstep(input logic [7:0] m);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s[16];
        logic [7:0] k[16];
        logic [7:0] t[16];
        logic [7:0] w[4];
        logic [7:0] rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbx(s[i]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            w[0] = sbx(k[13]) ^ rc;
            w[1] = sbx(k[14]);
            w[2] = sbx(k[15]);
            w[3] = sbx(k[12]);
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) begin
                    k[4*c+j] = k[4*c+j] ^ w[j];
                    w[j]     = k[4*c+j];
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
            rc = xt(rc);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic push_ct(input logic [127:0] ct);
        for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
    endtask

    // Holds reset for one edge, releases it, then drives 16 bytes; is_bist
    // flips after the first byte to show it is only sampled once.
    task automatic start_load(input logic [127:0] key, input logic [127:0] pt,
                              input logic bist, input logic en);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
        en_lsfr_misr = en;
        for (int k = 0; k < 16; k++) begin
            key_in  = key[127-8*k -: 8];
            d_in    = pt[127-8*k -: 8];
            is_bist = (k == 0) ? bist : ~bist;
            @(negedge clk);
            edge_n++;
        end
    endtask

    task automatic run_to(input int n_end, input logic [7:0] hold);
        logic [7:0] e;
        while (edge_n < n_end) begin
            @(negedge clk);
            edge_n++;
            check1("d_vld", d_vld, (edge_n >= 186 && edge_n <= 201));
            check1("DONE", DONE, (edge_n >= 202));
            if (edge_n >= 186 && edge_n <= 201) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $error("FAIL sb_empty @edge %0d: observed d_out %02h expected none", edge_n, d_out);
                end else begin
                    e = exp_q.pop_front();
                    check8("d_out", d_out, e);
                end
            end else if (edge_n >= 202) begin
                check8("d_out_final", d_out, hold);
            end
        end
    endtask

    initial begin
        logic [127:0] rk, rp, kv, dv, ct;
        logic [7:0]   lk, ld, m;

        repeat (3) @(negedge clk);
        check8("rst_d_out", d_out, 8'h00);
        check1("rst_d_vld", d_vld, 1'b0);
        check1("rst_DONE", DONE, 1'b0);

        // FIPS-197 appendix C vector
        push_ct(C1);
        start_load(K1, P1, 1'b0, 1'b0);
        run_to(212, C1[7:0]);
        check8("sb_drained", 8'(exp_q.size()), 8'h00);

        // Asynchronous reset inside round 4, then a fresh encryption
        push_ct(C2);
        start_load(K2, P2, 1'b0, 1'b0);
        run_to(75, 8'h00);
        #2 rst = 1'b0;
        #1;
        check8("rnd4_rst_d_out", d_out, 8'h00);
        check1("rnd4_rst_d_vld", d_vld, 1'b0);
        check1("rnd4_rst_DONE", DONE, 1'b0);
        start_load(K2, P2, 1'b0, 1'b0);
        run_to(212, C2[7:0]);

        // Random vector against the model, with a reset while streaming out
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        ct = aes_ref(rk, rp);
        push_ct(ct);
        start_load(rk, rp, 1'b0, 1'b1);
        run_to(190, 8'h00);
        #1 rst = 1'b0;
        #1;
        check1("out_rst_d_vld", d_vld, 1'b0);
        check8("out_rst_d_out", d_out, 8'h00);
        check1("out_rst_DONE", DONE, 1'b0);
        exp_q.delete();
        push_ct(ct);
        start_load(rk, rp, 1'b0, 1'b1);
        run_to(212, ct[7:0]);

`ifdef AES_BIST_EN
        // BIST with stepping LFSRs: pins carry random junk
        lk = 8'hA5;
        ld = 8'h01;
        for (int i = 0; i < 16; i++) begin
            kv[127-8*i -: 8] = lk;
            dv[127-8*i -: 8] = ld;
            lk = lstep(lk);
            ld = lstep(ld);
        end
        ct = aes_ref(kv, dv);
        m = 8'h00;
        for (int i = 0; i < 16; i++) m = lstep(m) ^ ct[127-8*i -: 8];
        push_ct(ct);
        start_load({$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        run_to(212, m);

        // BIST with LFSRs/MISR frozen: seeds everywhere, signature stays zero
        kv = {16{8'hA5}};
        dv = {16{8'h01}};
        push_ct(aes_ref(kv, dv));
        start_load(K2, P2, 1'b1, 1'b0);
        run_to(212, 8'h00);
`else
        // Without the self-test logic is_bist is ignored
        lk = 8'h00;
        ld = 8'h00;
        m  = 8'h00;
        kv = '0;
        dv = '0;
        push_ct(C1);
        start_load(K1, P1, 1'b1, 1'b1);
        run_to(212, C1[7:0]);
`endif
        check8("sb_final_drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
